serial_subtractor: RTL and testbench

//   Bit-serial ripple subtractor; the counterpart of the combinational adder

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand bus for the bit-serial subtractor.
// The master issues operations; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: computes a - b - bin LSB first, one full-subtractor
// step per clock, with a start/busy/done handshake and registered results.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic bit_a, bit_b, bit_d, br_next, last_bit;

  // Single full-subtractor cell, reused every cycle on the operand LSBs.
  always_comb begin
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    bit_d    = bit_a ^ bit_b ^ br_q;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    last_bit = (cnt_q == CntLast);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; busy is asserted from the accepting edge onward.
  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = done_q;
    bus.diff = diff_q;
    bus.bout = bout_q;
  end

  // Datapath next-state: capture on accepted start, shift one bit per RUN cycle.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          br_d  = bus.bin;
          cnt_d = '0;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_bit) begin
          // res_d already holds the final bit, so the result is complete here.
          diff_d = {bit_d, res_q[WIDTH-1:1]};
          bout_d = br_next;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of the bit-serial subtractor at WIDTH 8, 2 and 16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serial_subtractor_if #(.WIDTH(8))  bus8  ();
  serial_subtractor_if #(.WIDTH(2))  bus2  ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  serial_subtractor #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Stimulus only: issue a one-cycle start on the WIDTH=8 instance, returns at the
  // first falling edge after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.bin   = bin;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_w8: busy=%b done=%b diff=%h bout=%b, want 0 0 00 0",
               bus8.busy, bus8.done, bus8.diff, bus8.bout);
    end
    n_vec++;
    if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus16.busy !== 1'b0 ||
        bus16.done !== 1'b0 || bus16.diff !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_w2_w16: busy2=%b done2=%b busy16=%b done16=%b diff16=%h, want 0",
               bus2.busy, bus2.done, bus16.busy, bus16.done, bus16.diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    start_op8(8'h35, 8'h12, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      n_vec++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, want 1 0", k, bus8.busy, bus8.done);
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0 || bus8.diff !== 8'h23 || bus8.bout !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b diff=%h bout=%b, want 1 0 23 0",
               bus8.done, bus8.busy, bus8.diff, bus8.bout);
    end
    @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b0 || bus8.diff !== 8'h23) begin
      n_err++;
      $display("FAIL basic_hold: done=%b diff=%h, want 0 23", bus8.done, bus8.diff);
    end
  endtask

  task automatic test_wrap;
    start_op8(8'h00, 8'h01, 1'b0);
    repeat (8) @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b1 || bus8.diff !== 8'hFF || bus8.bout !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_underflow: done=%b diff=%h bout=%b, want 1 ff 1",
               bus8.done, bus8.diff, bus8.bout);
    end
    // Issued in the done cycle of the previous op.
    start_op8(8'h80, 8'h7F, 1'b1);
    repeat (8) @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b1 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_borrow_in: done=%b diff=%h bout=%b, want 1 00 0",
               bus8.done, bus8.diff, bus8.bout);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int         n_done;
    logic [7:0] diff_at9;
    logic       bout_at9;
    n_done   = 0;
    diff_at9 = 8'hxx;
    bout_at9 = 1'bx;
    start_op8(8'hA0, 8'h0A, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (bus8.done === 1'b1) n_done++;
      if (k == 9) begin
        diff_at9 = bus8.diff;
        bout_at9 = bus8.bout;
      end
      if (k == 3) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
      end
      if (k == 4) bus8.start = 1'b0;
    end
    n_vec++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL ignore_done_count: saw %0d done pulses, want 1", n_done);
    end
    n_vec++;
    if (diff_at9 !== 8'h96 || bout_at9 !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_result: diff=%h bout=%b at done cycle, want 96 0", diff_at9, bout_at9);
    end
    n_vec++;
    if (bus8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_busy: busy=%b after op, want 0", bus8.busy);
    end
  endtask

  task automatic test_back_to_back;
    bus8.start = 1'b1;
    bus8.a     = 8'h55;
    bus8.b     = 8'h05;
    bus8.bin   = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) begin
        bus8.a = 8'h10;
        bus8.b = 8'h20;
      end
    end
    n_vec++;
    if (bus8.done !== 1'b1 || bus8.diff !== 8'h50 || bus8.bout !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: done=%b diff=%h bout=%b, want 1 50 0",
               bus8.done, bus8.diff, bus8.bout);
    end
    @(negedge clk);
    bus8.start = 1'b0;
    n_vec++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", bus8.busy, bus8.done);
    end
    repeat (7) @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b0 || bus8.diff !== 8'h50) begin
      n_err++;
      $display("FAIL b2b_early: done=%b diff=%h, want 0 50", bus8.done, bus8.diff);
    end
    @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b1 || bus8.diff !== 8'hF0 || bus8.bout !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: done=%b diff=%h bout=%b, want 1 f0 1",
               bus8.done, bus8.diff, bus8.bout);
    end
  endtask

  task automatic test_reset_abort;
    int n_done;
    n_done = 0;
    start_op8(8'h35, 8'h12, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_status: busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
    end
    n_vec++;
    if (bus8.diff !== 8'h00 || bus8.bout !== 1'b0) begin
      n_err++;
      $display("FAIL abort_result: diff=%h bout=%b, want 00 0", bus8.diff, bus8.bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0 || bus8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: saw %0d done pulses, busy=%b, want 0 0", n_done, bus8.busy);
    end
    start_op8(8'h35, 8'h12, 1'b0);
    repeat (8) @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b1 || bus8.diff !== 8'h23 || bus8.bout !== 1'b0) begin
      n_err++;
      $display("FAIL abort_recover: done=%b diff=%h bout=%b, want 1 23 0",
               bus8.done, bus8.diff, bus8.bout);
    end
    @(negedge clk);
  endtask

  task automatic test_random_w2;
    logic [1:0] a, b;
    logic       bin;
    logic [2:0] expv;
    int         early;
    for (int i = 0; i < 1000; i++) begin
      a    = 2'($urandom);
      b    = 2'($urandom);
      bin  = 1'($urandom);
      expv = {1'b0, a} - {1'b0, b} - {2'b00, bin};
      bus2.start = 1'b1;
      bus2.a     = a;
      bus2.b     = b;
      bus2.bin   = bin;
      @(posedge clk);
      early = 0;
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        if (k == 1) bus2.start = 1'b0;
        if (bus2.done === 1'b1) early++;
      end
      @(negedge clk);
      n_vec++;
      if (early != 0 || bus2.done !== 1'b1) begin
        n_err++;
        $display("FAIL w2_latency op %0d: early=%0d done=%b, want 0 1", i, early, bus2.done);
      end
      n_vec++;
      if ({bus2.bout, bus2.diff} !== expv) begin
        n_err++;
        $display("FAIL w2_result a=%h b=%h bin=%b: got {bout,diff}=%h, want %h",
                 a, b, bin, {bus2.bout, bus2.diff}, expv);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random_w16;
    logic [15:0] a, b;
    logic        bin;
    logic [16:0] expv;
    int          early;
    for (int i = 0; i < 1000; i++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      bin  = 1'($urandom);
      expv = {1'b0, a} - {1'b0, b} - {16'h0000, bin};
      bus16.start = 1'b1;
      bus16.a     = a;
      bus16.b     = b;
      bus16.bin   = bin;
      @(posedge clk);
      early = 0;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (k == 1) bus16.start = 1'b0;
        if (bus16.done === 1'b1) early++;
      end
      @(negedge clk);
      n_vec++;
      if (early != 0 || bus16.done !== 1'b1) begin
        n_err++;
        $display("FAIL w16_latency op %0d: early=%0d done=%b, want 0 1", i, early, bus16.done);
      end
      n_vec++;
      if ({bus16.bout, bus16.diff} !== expv) begin
        n_err++;
        $display("FAIL w16_result a=%h b=%h bin=%b: got {bout,diff}=%h, want %h",
                 a, b, bin, {bus16.bout, bus16.diff}, expv);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.start  = 1'b0;  bus8.a  = '0; bus8.b  = '0; bus8.bin  = 1'b0;
    bus2.start  = 1'b0;  bus2.a  = '0; bus2.b  = '0; bus2.bin  = 1'b0;
    bus16.start = 1'b0;  bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;

    test_reset();
    test_basic();
    test_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random_w2();
    test_random_w16();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
